// File: rtl/mem_copy_engine_pkg.sv
// mem_copy_engine_pkg: memory request widths and the
// latched copy command shared by the copy engine.
package mem_copy_engine_pkg;

  localparam int MEM_ADDR_W = 16;
  localparam int MEM_DATA_W = 16;

  typedef logic [MEM_ADDR_W-1:0] maddr_t;
  typedef logic [MEM_DATA_W-1:0] mdata_t;

  typedef struct packed {
    maddr_t      src;
    maddr_t      dst;
    logic [15:0] len;
  } copy_cmd_t;

  function automatic maddr_t addr_inc(input maddr_t a);
    return a + maddr_t'(1);
  endfunction

endpackage

// File: rtl/mem_copy_engine.sv
// mem_copy_engine: word-at-a-time block copy initiator
// on the memory request handshake, with request timeout.
module mem_copy_engine
  import mem_copy_engine_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] src_addr,
  input  logic [15:0] dst_addr,
  input  logic [15:0] len,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] words_done,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_read_en,
  output logic        mem_write_en,
  input  logic [15:0] mem_rdata,
  input  logic        mem_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_GAP,
    S_WR_REQ,
    S_WR_GAP
  } state_t;

  localparam logic [15:0] TO_LAST =
    16'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  copy_cmd_t   cmd_q, cmd_d;
  logic [15:0] words_q, words_d;
  logic [15:0] wait_q, wait_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  maddr_t      addr_q, addr_d;
  mdata_t      wdata_q, wdata_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic        in_req;
  logic        timeout;

  assign in_req  = (state_q == S_RD_REQ) ||
                   (state_q == S_WR_REQ);
  assign timeout = in_req && !mem_done &&
                   (wait_q == TO_LAST);

  // State and all registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cmd_q   <= '0;
      words_q <= '0;
      wait_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      words_q <= words_d;
      wait_q  <= wait_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
    end
  end

  // Next state and next register values; an expired
  // wait overrides whatever the request state chose.
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    words_d = words_q;
    wait_d  = wait_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    error_d = error_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          error_d = 1'b0;
          if (len != '0) begin
            cmd_d   = '{src: src_addr,
                        dst: dst_addr,
                        len: len};
            words_d = '0;
            wait_d  = '0;
            busy_d  = 1'b1;
            rd_d    = 1'b1;
            addr_d  = src_addr;
            state_d = S_RD_REQ;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_RD_REQ: begin
        if (mem_done) begin
          wdata_d = mem_rdata;
          rd_d    = 1'b0;
          state_d = S_RD_GAP;
        end else begin
          wait_d = wait_q + 16'd1;
        end
      end
      S_RD_GAP: begin
        wr_d    = 1'b1;
        addr_d  = cmd_q.dst;
        wait_d  = '0;
        state_d = S_WR_REQ;
      end
      S_WR_REQ: begin
        if (mem_done) begin
          wr_d      = 1'b0;
          words_d   = words_q + 16'd1;
          cmd_d.src = addr_inc(cmd_q.src);
          cmd_d.dst = addr_inc(cmd_q.dst);
          state_d   = S_WR_GAP;
        end else begin
          wait_d = wait_q + 16'd1;
        end
      end
      S_WR_GAP: begin
        if (words_q == cmd_q.len) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          rd_d    = 1'b1;
          addr_d  = cmd_q.src;
          wait_d  = '0;
          state_d = S_RD_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (timeout) begin
      rd_d    = 1'b0;
      wr_d    = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b1;
      error_d = 1'b1;
      state_d = S_IDLE;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;
  assign words_done   = words_q;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign mem_read_en  = rd_q;
  assign mem_write_en = wr_q;

endmodule

// File: tb/tb_mem_copy_engine.sv
// tb_mem_copy_engine: random-latency stub responder and
// a word-list copy model checking mem_copy_engine.
module tb_mem_copy_engine;

  typedef logic [32:0] acc_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] src_addr = '0;
  logic [15:0] dst_addr = '0;
  logic [15:0] len = '0;
  logic        busy, done, error;
  logic [15:0] words_done, mem_addr, mem_wdata;
  logic        mem_read_en, mem_write_en;
  logic [15:0] mem_rdata = '0;
  logic        mem_done = 1'b0;

  mem_copy_engine #(.TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .rst(rst), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr),
    .len(len), .busy(busy), .done(done),
    .error(error), .words_done(words_done),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_read_en(mem_read_en),
    .mem_write_en(mem_write_en),
    .mem_rdata(mem_rdata), .mem_done(mem_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  logic [15:0] mem [0:65535];
  logic [15:0] ref_mem [0:65535];
  acc_t log_q[$];
  acc_t exp_q[$];

  int hang_at = -1;
  int resp_n = 0;
  int remain = 0;
  bit rbusy = 0;
  int wait_sum = 0;

  int viol_both, viol_stab, viol_gap;
  int en_cycles, n_done, busy_seen;
  int done_busy, run, last_run;
  logic pv_rd = 0, pv_wr = 0;
  logic [15:0] pv_addr = '0, pv_wdata = '0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Stub responder: random 1..4 cycle latency, or
  // silence once hang_at responses have been given.
  always @(negedge clk) begin
    if (!rst) begin
      mem_done = 1'b0;
      rbusy = 0;
    end else if (mem_done) begin
      mem_done = 1'b0;
      rbusy = 0;
    end else if ((mem_read_en || mem_write_en) &&
                 !(hang_at >= 0 && resp_n == hang_at)) begin
      if (!rbusy) begin
        rbusy = 1;
        remain = $urandom_range(0, 3);
        wait_sum += remain + 1;
      end
      if (remain == 0) begin
        mem_done = 1'b1;
        resp_n++;
        if (mem_read_en) begin
          mem_rdata = mem[mem_addr];
          log_q.push_back({1'b0, mem_addr, mem_rdata});
        end else begin
          mem[mem_addr] = mem_wdata;
          log_q.push_back({1'b1, mem_addr, mem_wdata});
        end
      end else begin
        remain--;
      end
    end
  end

  // Handshake monitor.
  always @(negedge clk) begin
    if (mem_read_en && mem_write_en) viol_both++;
    if ((mem_read_en || mem_write_en) &&
        (pv_rd || pv_wr)) begin
      if (mem_read_en != pv_rd || mem_addr != pv_addr ||
          (mem_write_en && mem_wdata != pv_wdata))
        viol_stab++;
    end
    if ((pv_rd && mem_write_en) || (pv_wr && mem_read_en))
      viol_gap++;
    if (mem_read_en || mem_write_en) begin
      en_cycles++;
      run++;
    end else if (run > 0) begin
      last_run = run;
      run = 0;
    end
    if (done) n_done++;
    if (done && busy) done_busy++;
    if (busy) busy_seen++;
    pv_rd = mem_read_en;
    pv_wr = mem_write_en;
    pv_addr = mem_addr;
    pv_wdata = mem_wdata;
  end

  task automatic clear_stats();
    viol_both = 0; viol_stab = 0; viol_gap = 0;
    en_cycles = 0; n_done = 0; busy_seen = 0;
    done_busy = 0; run = 0; last_run = 0;
    wait_sum = 0; resp_n = 0;
    log_q.delete();
    exp_q.delete();
  endtask

  task automatic set_word(input logic [15:0] a,
                          input logic [15:0] d);
    mem[a] = d;
    ref_mem[a] = d;
  endtask

  // Forward word-by-word copy, modulo-2^16 addresses.
  task automatic model_copy(input logic [15:0] s,
                            input logic [15:0] d,
                            input int n);
    for (int i = 0; i < n; i++) begin
      logic [15:0] sa, da, v;
      sa = s + 16'(i);
      da = d + 16'(i);
      v = ref_mem[sa];
      ref_mem[da] = v;
      exp_q.push_back({1'b0, sa, v});
      exp_q.push_back({1'b1, da, v});
    end
  endtask

  task automatic compare_log();
    check("acc_count", log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < log_q.size())
        check($sformatf("acc[%0d]", i), log_q[i], exp_q[i]);
    end
  endtask

  task automatic compare_mem(input logic [15:0] d,
                             input int n);
    for (int i = 0; i < n; i++) begin
      logic [15:0] a;
      a = d + 16'(i);
      check($sformatf("mem[%0h]", a), mem[a], ref_mem[a]);
    end
  endtask

  task automatic issue(input logic [15:0] s,
                       input logic [15:0] d,
                       input logic [15:0] n);
    @(negedge clk);
    start = 1'b1;
    src_addr = s;
    dst_addr = d;
    len = n;
  endtask

  task automatic wait_done(output int t_done);
    int k;
    k = 0;
    while (!done && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check("done_seen", done, 1'b1);
    t_done = cyc;
  endtask

  task automatic run_copy(input logic [15:0] s,
                          input logic [15:0] d,
                          input logic [15:0] n);
    int t0, t1;
    clear_stats();
    hang_at = -1;
    model_copy(s, d, int'(n));
    issue(s, d, n);
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
    check("c1_busy_rd", {busy, mem_read_en, error},
          3'b110);
    wait_done(t1);
    check("latency", t1 - t0,
          1 + 2 * int'(n) + wait_sum);
    check("words_done", words_done, n);
    check("error", error, 1'b0);
    repeat (2) @(negedge clk);
    check("done_pulses", n_done, 1);
    check("done_busy", done_busy, 0);
    check("busy_end", busy, 1'b0);
    check("hs_viol", {viol_both, viol_stab, viol_gap},
          '0);
    check("en_cycles", en_cycles, wait_sum);
    compare_log();
    compare_mem(d, int'(n));
  endtask

  initial begin
    int t0, t1;
    int k;
    for (int i = 0; i < 65536; i++) begin
      mem[i] = 16'($urandom);
      ref_mem[i] = mem[i];
    end
    clear_stats();
    #2;
    check("rst_flags",
          {busy, done, error, mem_read_en, mem_write_en},
          5'b0);
    check("rst_addr", mem_addr, 16'h0);
    check("rst_wdata", mem_wdata, 16'h0);
    check("rst_words", words_done, 16'h0);
    repeat (3) @(negedge clk);
    rst = 1'b1;

    set_word(16'h0000, 16'hFFFF);
    run_copy(16'h0000, 16'h0001, 16'd1);
    check("t1_mem1", mem[1], 16'hFFFF);

    set_word(16'h0010, 16'h1111);
    set_word(16'h0011, 16'h2222);
    set_word(16'h0012, 16'h3333);
    set_word(16'h0013, 16'h4444);
    run_copy(16'h0010, 16'h0020, 16'd4);
    check("t2_mem23", mem[16'h23], 16'h4444);

    clear_stats();
    issue(16'h0050, 16'h0060, 16'd0);
    @(negedge clk);
    start = 1'b0;
    check("len0_c1", {done, busy}, 2'b10);
    repeat (4) @(negedge clk);
    check("len0_pulses", n_done, 1);
    check("len0_en", en_cycles, 0);
    check("len0_busy", busy_seen, 0);

    run_copy(16'hFFFE, 16'h0500, 16'd3);
    if (log_q.size() == 6) begin
      check("wrap_rd0", log_q[0][31:16], 16'hFFFE);
      check("wrap_rd1", log_q[2][31:16], 16'hFFFF);
      check("wrap_rd2", log_q[4][31:16], 16'h0000);
    end else begin
      check("wrap_log", log_q.size(), 6);
    end

    run_copy(16'h0100, 16'h0102, 16'd6);

    for (int r = 0; r < 10; r++) begin
      run_copy(16'($urandom), 16'($urandom),
               16'($urandom_range(1, 10)));
    end

    clear_stats();
    hang_at = 0;
    issue(16'h0040, 16'h0080, 16'd2);
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
    wait_done(t1);
    check("to_cycle", t1 - t0, 65);
    check("to_flags", {error, mem_read_en, busy},
          3'b100);
    check("to_words", words_done, 16'd0);
    @(negedge clk);
    check("to_run", last_run, 64);

    clear_stats();
    hang_at = 3;
    issue(16'h0040, 16'h0080, 16'd2);
    @(negedge clk);
    start = 1'b0;
    wait_done(t1);
    check("to2_flags", {error, mem_write_en}, 2'b10);
    check("to2_words", words_done, 16'd1);
    @(negedge clk);
    check("to2_run", last_run, 64);
    repeat (5) @(negedge clk);
    check("to2_hold", error, 1'b1);
    model_copy(16'h0040, 16'h0080, 1);
    compare_mem(16'h0080, 2);

    run_copy(16'h0700, 16'h0800, 16'd2);

    clear_stats();
    hang_at = -1;
    issue(16'h0200, 16'h0300, 16'd8);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1;
    src_addr = 16'h0900;
    dst_addr = 16'h0900;
    len = 16'd1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (words_done != 16'd3 && k < 500) begin
      @(negedge clk);
      k++;
    end
    check("mid_words", words_done, 16'd3);
    rst = 1'b0;
    #1;
    check("mid_rst_flags",
          {busy, done, error, mem_read_en, mem_write_en},
          5'b0);
    check("mid_rst_addr", mem_addr, 16'h0);
    check("mid_rst_wdata", mem_wdata, 16'h0);
    check("mid_rst_words", words_done, 16'h0);
    model_copy(16'h0200, 16'h0300, 3);
    compare_log();
    compare_mem(16'h0300, 8);
    check("mid_no_done", n_done, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    run_copy(16'h0200, 16'h0300, 16'd8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
